// File: rtl/spm_driver.sv
// Host-side driver for a serial-parallel multiplier array: loads x in parallel,
// streams y LSB first with sign/zero extension, and reassembles the 2*WIDTH product.
module spm_driver #(
  parameter int WIDTH  = 8,
  parameter int LAT    = 1,
  parameter int SIGNED = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  output logic [WIDTH-1:0]   spm_x,
  output logic               spm_clr,
  output logic               spm_y,
  input  logic               spm_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW + LAT);
  localparam int KW = $clog2(PW);

  localparam logic [CW-1:0] SHIFT_END = CW'(PW - 1);
  localparam logic [CW-1:0] DRAIN_END = CW'(PW + LAT - 1);
  localparam logic [CW-1:0] CAP_START = CW'(LAT);
  localparam logic [KW-1:0] CAP_END   = KW'(PW - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;   // cycles since SHIFT began; keeps counting through DRAIN
  logic [KW-1:0]    cap;
  logic [WIDTH-1:0] y_sr;
  logic             y_ext;

  // The top bit of y is never shifted out, so it supplies the sign extension.
  assign y_ext = (SIGNED != 0) ? y_sr[WIDTH-1] : 1'b0;

  // NOTE: reset is synchronous and covers every register, so a partial
  // product can never leak out after rst; all state uses <= so each edge
  // sees a consistent snapshot of the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap       <= '0;
      y_sr      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      spm_clr   <= 1'b0;
      spm_y     <= 1'b0;
      spm_x     <= '0;
      out_p     <= '0;
    end else begin
      spm_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            spm_x    <= in_x;
            y_sr     <= in_y;
            in_ready <= 1'b0;
            spm_clr  <= 1'b1;
            cnt      <= '0;
            cap      <= '0;
            out_p    <= '0;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          spm_y <= y_sr[0];
          y_sr  <= {y_ext, y_sr[WIDTH-1:1]};
          state <= SHIFT;
        end
        SHIFT, DRAIN: begin
          // Product bits trail the y bits by LAT cycles; cap saturates at the top bit.
          if (cnt >= CAP_START) begin
            out_p[cap] <= spm_p;
            if (cap != CAP_END) cap <= cap + 1'b1;
          end
          cnt <= cnt + 1'b1;
          if (state == SHIFT) begin
            if (cnt == SHIFT_END) begin
              spm_y <= 1'b0;
              state <= DRAIN;
            end else begin
              spm_y <= y_sr[0];
              y_sr  <= {y_ext, y_sr[WIDTH-1:1]};
            end
          end else if (cnt == DRAIN_END) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spm_driver.sv
// Bench for spm_driver: two instances (signed, unsigned) driven by a behavioural
// multiplier-array model, checked every cycle against a cycle-timeline model.
module tb_spm_driver;

  localparam int W        = 8;
  localparam int L        = 1;
  localparam int DONE_AGE = 2 * W + 2 + L;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid, in_ready, spm_clr, spm_y, out_valid, out_ready;
  logic [1:0]  spm_p = '0;
  logic [7:0]  in_x [2];
  logic [7:0]  in_y [2];
  logic [7:0]  spm_x [2];
  logic [15:0] out_p [2];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Instance 0 is signed, instance 1 unsigned.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    spm_driver #(.WIDTH(W), .LAT(L), .SIGNED(g == 0 ? 1 : 0)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_x(in_x[g]), .in_y(in_y[g]),
      .spm_x(spm_x[g]), .spm_clr(spm_clr[g]), .spm_y(spm_y[g]), .spm_p(spm_p[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_p(out_p[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mul(input logic [7:0] x, input logic [7:0] y, input bit sgn);
    int a, b;
    a = sgn ? int'($signed(x)) : int'(x);
    b = sgn ? int'($signed(y)) : int'(y);
    return 16'(a * b);
  endfunction

  function automatic logic exp_ybit(input logic [7:0] y, input int k, input bit sgn);
    if (k < 8) return y[k];
    return sgn ? y[7] : 1'b0;
  endfunction

  // Multiplier array: bit k of x*Y depends only on y bits 0..k, emitted one cycle later.
  int          ak [2] = '{16, 16};
  logic [15:0] ay [2];
  logic [15:0] xe, pr;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (spm_clr[i]) begin
        ay[i] = '0;
        ak[i] = 0;
        spm_p[i] <= 1'b0;
      end else if (ak[i] < 16) begin
        ay[i][ak[i]] = spm_y[i];
        xe = (i == 0) ? {{8{spm_x[i][7]}}, spm_x[i]} : {8'h00, spm_x[i]};
        pr = xe * ay[i];
        spm_p[i] <= pr[ak[i]];
        ak[i]++;
      end else begin
        spm_p[i] <= 1'b0;
      end
    end
  end

  // Timeline model: age = cycle number relative to acceptance (0 = idle).
  int          age [2] = '{0, 0};
  logic [7:0]  ex [2];
  logic [7:0]  ey [2];
  bit          known [2];
  logic [15:0] pval [2];
  bit          armed = 1'b0;
  int          cyc = 0;
  int          dut_acc [$];

  always @(posedge clk) begin
    if (!rst && in_valid[0] && in_ready[0]) dut_acc.push_back(cyc);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        age[i] = 0; ex[i] = '0; ey[i] = '0; known[i] = 1'b1; pval[i] = '0;
      end else if (age[i] == 0) begin
        if (in_valid[i]) begin
          age[i] = 1; ex[i] = in_x[i]; ey[i] = in_y[i]; known[i] = 1'b0;
        end
      end else if (age[i] >= DONE_AGE) begin
        if (out_ready[i]) begin
          age[i] = 0; known[i] = 1'b0;
        end
      end else begin
        age[i]++;
        if (age[i] == DONE_AGE) begin
          known[i] = 1'b1;
          pval[i]  = mul(ex[i], ey[i], i == 0);
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("in_ready%0d", i), in_ready[i], age[i] == 0);
        check($sformatf("out_valid%0d", i), out_valid[i], age[i] >= DONE_AGE);
        check($sformatf("spm_clr%0d", i), spm_clr[i], age[i] == 1);
        check($sformatf("spm_y%0d", i), spm_y[i],
              (age[i] >= 2 && age[i] <= 2 * W + 1) ? exp_ybit(ey[i], age[i] - 2, i == 0) : 1'b0);
        check($sformatf("spm_x%0d", i), spm_x[i], ex[i]);
        if (known[i]) check($sformatf("out_p%0d", i), out_p[i], pval[i]);
      end
    end
  end

  // Waits for idle, presents operands for one acceptance, then scrambles them.
  task automatic start(input int i, input logic [7:0] x, input logic [7:0] y);
    int w = 0;
    @(negedge clk);
    while (!in_ready[i] && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("start_ready", in_ready[i], 1'b1);
    in_valid[i] = 1'b1; in_x[i] = x; in_y[i] = y;
    @(negedge clk);
    in_valid[i] = 1'b0; in_x[i] = ~x; in_y[i] = ~y;
  endtask

  // Called at the negedge of cycle 1; returns at the negedge where out_valid is seen.
  task automatic collect(input int i, output int clr_c, output int done_c,
                         output logic [15:0] yseq, output logic [15:0] p);
    clr_c = -1; done_c = -1; yseq = '0; p = '0;
    for (int c = 1; c < 60 && done_c < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (spm_clr[i] && clr_c < 0) clr_c = c;
      if (c >= 2 && c <= 2 * W + 1) yseq[c-2] = spm_y[i];
      if (out_valid[i]) begin
        done_c = c;
        p = out_p[i];
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          clr_c, done_c, seen;
    bit          changed;
    logic [15:0] ys, p;
    logic [15:0] res [$];

    rst = 1'b1; in_valid = '0; out_ready = 2'b11;
    in_x[0] = '0; in_x[1] = '0; in_y[0] = '0; in_y[1] = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready[0], 1'b1);
    check("reset_out_valid", out_valid[0], 1'b0);
    check("reset_out_p", out_p[0], 16'h0000);
    check("reset_spm_x", spm_x[0], 8'h00);
    rst = 1'b0;

    // 3 * 5 signed: bit order, timing of clear and result.
    start(0, 8'd3, 8'd5);
    collect(0, clr_c, done_c, ys, p);
    check("t1_clr_cycle", clr_c, 1);
    check("t1_yseq", ys, 16'h0005);
    check("t1_done_cycle", done_c, 19);
    check("t1_out_p", p, 16'h000F);

    // 5 * -3 signed: extension bits are ones.
    start(0, 8'h05, 8'hFD);
    collect(0, clr_c, done_c, ys, p);
    check("t2_yseq", ys, 16'hFFFD);
    check("t2_out_p", p, 16'hFFF1);

    // 255 * 255 unsigned: extension bits are zeros.
    start(1, 8'hFF, 8'hFF);
    collect(1, clr_c, done_c, ys, p);
    check("t3_yseq", ys, 16'h00FF);
    check("t3_out_p", p, 16'hFE01);

    // Backpressure: result held, second request ignored.
    out_ready[0] = 1'b0;
    start(0, 8'h7F, 8'h80);
    collect(0, clr_c, done_c, ys, p);
    check("bp_done_cycle", done_c, 19);
    check("bp_out_p", p, 16'hC080);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 3) begin
        in_valid[0] = 1'b1; in_x[0] = 8'h11; in_y[0] = 8'h22;
      end else begin
        in_valid[0] = 1'b0;
      end
      check("bp_hold_valid", out_valid[0], 1'b1);
      check("bp_hold_p", out_p[0], 16'hC080);
      check("bp_hold_in_ready", in_ready[0], 1'b0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid[0], 1'b0);
    check("bp_release_ready", in_ready[0], 1'b1);

    // Reset at cycle 7 of an operation.
    start(0, 8'd3, 8'd5);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready[0], 1'b1);
    check("rst_out_valid", out_valid[0], 1'b0);
    check("rst_spm_y", spm_y[0], 1'b0);
    check("rst_spm_clr", spm_clr[0], 1'b0);
    check("rst_spm_x", spm_x[0], 8'h00);
    check("rst_out_p", out_p[0], 16'h0000);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    check("rst_no_result", seen, 0);
    start(0, 8'd2, 8'd7);
    collect(0, clr_c, done_c, ys, p);
    check("rst_next_out_p", p, 16'h000E);

    // Back-to-back with in_valid held high.
    @(negedge clk);
    dut_acc.delete();
    changed = 1'b0;
    in_valid[0] = 1'b1; in_x[0] = 8'd3; in_y[0] = 8'd5;
    for (int k = 0; k < 80 && res.size() < 2; k++) begin
      @(negedge clk);
      if (dut_acc.size() == 1 && !changed) begin
        in_x[0] = 8'd2; in_y[0] = 8'd7; changed = 1'b1;
      end
      if (dut_acc.size() >= 2) in_valid[0] = 1'b0;
      if (out_valid[0]) res.push_back(out_p[0]);
    end
    in_valid[0] = 1'b0;
    check("b2b_results", res.size(), 2);
    check("b2b_accepts", dut_acc.size(), 2);
    if (res.size() == 2) begin
      check("b2b_first_p", res[0], 16'h000F);
      check("b2b_second_p", res[1], 16'h000E);
    end
    if (dut_acc.size() == 2) check("b2b_spacing", dut_acc[1] - dut_acc[0], 2 * W + L + 3);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
